// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage MIPS pipeline.
// Fetches over a req/ready wait-state interface, honours hazard stalls and ID redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  // IDLE is the one-cycle post-reset state that keeps imem_req low.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } stateT;

  stateT       stateR, stateNxt;
  logic [31:0] pcR, pcNxt;
  logic [31:0] instrR, instrNxt;
  logic [31:0] pc4R, pc4Nxt;
  logic        validR, validNxt;
  logic [31:0] holdR, holdNxt;
  logic [31:0] pendR, pendNxt;
  logic        reqR;

  logic        stall;
  logic        doRedir;
  logic [31:0] target;
  logic [31:0] pcPlus4;
  logic        flushIfId;
  logic        loadIfId;
  logic [31:0] loadData;

  assign stall   = !PCWrite || !IF_ID_Write;
  assign doRedir = redirect && IF_ID_Write;
  assign target  = {redirect_pc[31:2], 2'b00};
  assign pcPlus4 = pcR + 32'd4;

  // Next-state, PC and IF/ID selection.
  always_comb begin
    stateNxt  = stateR;
    pcNxt     = pcR;
    holdNxt   = holdR;
    pendNxt   = pendR;
    flushIfId = 1'b0;
    loadIfId  = 1'b0;
    loadData  = imem_rdata;
    case (stateR)
      IDLE: begin
        stateNxt = FETCH;
      end
      FETCH: begin
        if (doRedir) begin
          flushIfId = 1'b1;
          if (imem_ready) begin
            pcNxt = target;
          end else begin
            pendNxt  = target;
            stateNxt = DRAIN;
          end
        end else if (imem_ready && !stall) begin
          loadIfId = 1'b1;
          pcNxt    = pcPlus4;
        end else if (imem_ready) begin
          holdNxt   = imem_rdata;
          stateNxt  = HOLD;
          flushIfId = IF_ID_Write;
        end else begin
          flushIfId = IF_ID_Write;
        end
      end
      HOLD: begin
        if (doRedir) begin
          flushIfId = 1'b1;
          pcNxt     = target;
          stateNxt  = FETCH;
        end else if (!stall) begin
          loadIfId = 1'b1;
          loadData = holdR;
          pcNxt    = pcPlus4;
          stateNxt = FETCH;
        end else begin
          flushIfId = IF_ID_Write;
        end
      end
      DRAIN: begin
        // The outstanding fetch must complete before the pending target is issued.
        flushIfId = 1'b1;
        if (doRedir) begin
          pendNxt = target;
        end else begin
          pendNxt = pendR;
        end
        if (imem_ready) begin
          pcNxt    = doRedir ? target : pendR;
          stateNxt = FETCH;
        end else begin
          stateNxt = DRAIN;
        end
      end
      default: begin
        stateNxt  = IDLE;
        flushIfId = 1'b1;
      end
    endcase

    if (flushIfId) begin
      instrNxt = NOP_INSTR;
      pc4Nxt   = 32'h0000_0000;
      validNxt = 1'b0;
    end else if (loadIfId) begin
      instrNxt = loadData;
      pc4Nxt   = pcPlus4;
      validNxt = 1'b1;
    end else begin
      instrNxt = instrR;
      pc4Nxt   = pc4R;
      validNxt = validR;
    end
  end

  // State, PC, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR <= IDLE;
      pcR    <= RESET_PC;
      instrR <= NOP_INSTR;
      pc4R   <= 32'h0000_0000;
      validR <= 1'b0;
      holdR  <= 32'h0000_0000;
      pendR  <= 32'h0000_0000;
      reqR   <= 1'b0;
    end else begin
      stateR <= stateNxt;
      pcR    <= pcNxt;
      instrR <= instrNxt;
      pc4R   <= pc4Nxt;
      validR <= validNxt;
      holdR  <= holdNxt;
      pendR  <= pendNxt;
      reqR   <= (stateNxt == FETCH) || (stateNxt == DRAIN);
    end
  end

  assign imem_req    = reqR;
  assign imem_addr   = pcR;
  assign pc          = pcR;
  assign if_id_instr = instrR;
  assign if_id_pc4   = pc4R;
  assign if_id_valid = validR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed test-plan sequence followed by
// randomized stalls, redirects, wait states and resets against a behavioural model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWrite = 1'b1;
  logic        IF_ID_Write = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int nChecks = 0;
  int nFails  = 0;

  // Model: fetch mode 0=starting after reset, 1=fetching, 2=holding a word, 3=discarding.
  int          mMode = 0;
  logic [31:0] mPc = RESET_PC;
  logic [31:0] mTarget = 32'h0000_0000;
  logic        mValid = 1'b0;
  logic [31:0] mInstr = NOP_INSTR;
  logic [31:0] mPc4 = 32'h0000_0000;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  task automatic expectEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic flushModel();
    mValid = 1'b0;
    mInstr = NOP_INSTR;
    mPc4   = 32'h0000_0000;
  endtask

  task automatic presentModel(input logic [31:0] a);
    mValid = 1'b1;
    mInstr = memWord(a);
    mPc4   = a + 32'd4;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    logic        stallNow;
    logic        redirNow;
    logic [31:0] tgt;
    stallNow = !PCWrite || !IF_ID_Write;
    redirNow = redirect && IF_ID_Write;
    tgt      = redirect_pc & 32'hFFFF_FFFC;
    if (rst) begin
      mMode = 0;
      mPc   = RESET_PC;
      flushModel();
    end else if (mMode == 0) begin
      mMode = 1;
    end else if (mMode == 2) begin
      if (redirNow) begin
        flushModel();
        mPc = tgt;
        mMode = 1;
      end else if (!stallNow) begin
        presentModel(mPc);
        mPc = mPc + 32'd4;
        mMode = 1;
      end else if (IF_ID_Write) begin
        flushModel();
      end
    end else if (mMode == 3) begin
      flushModel();
      if (redirNow) mTarget = tgt;
      if (imem_ready) begin
        mPc = mTarget;
        mMode = 1;
      end
    end else begin
      if (redirNow) begin
        flushModel();
        if (imem_ready) mPc = tgt;
        else begin
          mTarget = tgt;
          mMode = 3;
        end
      end else if (imem_ready && !stallNow) begin
        presentModel(mPc);
        mPc = mPc + 32'd4;
      end else begin
        if (imem_ready) mMode = 2;
        if (IF_ID_Write) flushModel();
      end
    end
  endtask

  task automatic checkAll();
    expectEq("pc", pc, mPc);
    expectEq("imem_addr", imem_addr, mPc);
    expectEq("imem_req", {31'd0, imem_req}, {31'd0, (mMode == 1) || (mMode == 3)});
    expectEq("if_id_valid", {31'd0, if_id_valid}, {31'd0, mValid});
    expectEq("if_id_instr", if_id_instr, mInstr);
    expectEq("if_id_pc4", if_id_pc4, mPc4);
  endtask

  task automatic step(input logic r, input logic pw, input logic iw, input logic rd,
                      input logic [31:0] rp, input logic ry);
    rst         = r;
    PCWrite     = pw;
    IF_ID_Write = iw;
    redirect    = rd;
    redirect_pc = rp;
    imem_ready  = ry;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  initial begin
    // Reset and sequential fetch with zero wait states.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("rst_req", {31'd0, imem_req}, 32'd0);
    expectEq("rst_valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    expectEq("first_addr", imem_addr, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("seq_pc4_4", if_id_pc4, 32'h4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("seq_addr_8", imem_addr, 32'h8);
    // Load-use stall at pc=8, then release from the hold buffer.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    expectEq("stall_pc", pc, 32'h8);
    expectEq("stall_pc4", if_id_pc4, 32'h8);
    expectEq("hold_req", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("hold_instr", if_id_instr, memWord(32'h8));
    // Redirect with ready at pc=C.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    expectEq("redir_pc", pc, 32'h40);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("redir_instr", if_id_instr, memWord(32'h40));
    // Redirect during a wait-state fetch at pc=10.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      expectEq("drain_addr", imem_addr, 32'h10);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("drain_done_addr", imem_addr, 32'h80);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    // Redirect while IF/ID is frozen is ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    expectEq("frozen_pc", pc, 32'h84);
    expectEq("frozen_pc4", if_id_pc4, 32'h84);
    // Reset during a wait-state fetch; the late ready is ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("late_ready_pc", pc, 32'h0);
    // Low-bit masking and 32-bit PC wrap.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    expectEq("mask_pc", pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    expectEq("wrap_pc", pc, 32'h0);
    expectEq("wrap_pc4", if_id_pc4, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, pw, iw, rd, ry;
      int sel;
      r   = ($urandom_range(0, 99) == 0);
      sel = $urandom_range(0, 9);
      pw  = !(sel < 2 || sel == 2);
      iw  = !(sel < 2 || sel == 3);
      rd  = ($urandom_range(0, 7) == 0);
      ry  = ($urandom_range(0, 9) < 6);
      step(r, pw, iw, rd, $urandom, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and issues fetches to instruction memory over a req/ready wait-state interface.
- Presents fetched instructions to ID.
- Obeys the stall controls PCWrite/IF_ID_Write from the load-use hazard unit.
- Applies branch/jump redirects from ID and flushes the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush/reset (sll $0,$0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- PCWrite  input  1  0 = freeze PC (hazard unit).
- IF_ID_Write  input  1  0 = freeze IF/ID register (hazard unit).
- redirect  input  1  taken branch or jump resolved in ID this cycle.
- redirect_pc  input  32  target address for redirect.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word-aligned.
- imem_rdata  input  32  instruction data, valid when imem_ready=1.
- imem_ready  input  1  completes the current request this cycle.
- pc  output  32  current fetch PC.
- if_id_instr  output  32  IF/ID instruction.
- if_id_pc4  output  32  IF/ID PC+4.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset, sync, active-high:
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
  - imem_req=0; state=FETCH on the cycle after rst falls.
  - rst mid-fetch abandons any outstanding request; the returning imem_ready/data is ignored.
- stall = !PCWrite || !IF_ID_Write.
- redirect is honoured only when IF_ID_Write=1. When frozen it is ignored, because ID re-presents it.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=pc. Address and req stay stable until imem_ready.
  - ready & !stall & !redirect: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay in FETCH. This gives back-to-back fetches, one per cycle with zero wait states.
  - ready & stall: capture imem_rdata into the hold buffer, leave pc unchanged, go to HOLD.
  - redirect & ready: discard data; pc <= redirect_pc; IF/ID <= {NOP_INSTR, 0, valid=0}; stay in FETCH.
  - redirect & !ready: store redirect_pc in a pending register, flush IF/ID, go to DRAIN.
  - !ready & !redirect: wait; IF/ID holds if IF_ID_Write=0. Otherwise IF/ID loads a bubble (valid=0, NOP_INSTR).
- HOLD:
  - imem_req=0.
  - When !stall: IF/ID <= {hold buffer, pc+4, 1}; pc <= pc+4; go to FETCH.
  - redirect in HOLD (IF_ID_Write=1): drop the buffer, pc <= redirect_pc, flush IF/ID, go to FETCH.
- DRAIN:
  - imem_req=1 with the old address until imem_ready. Data is discarded.
  - Then pc <= pending target, go to FETCH.
  - IF/ID stays flushed (valid=0).
  - A new redirect in DRAIN overwrites the pending target.
- Simultaneous redirect and stall with IF_ID_Write=1, PCWrite=0: redirect wins, and the PC is loaded.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- The low two bits of redirect_pc are forced to 0.
- if_id_pc4 always equals fetched pc+4.

Test Plan:
- Reset, then imem_ready=1 constant with rdata=pc-derived: imem_addr sequence 0,4,8,C. if_id_valid=1 from the 2nd cycle; if_id_pc4 = 4,8,C.
- Load-use stall: PCWrite=IF_ID_Write=0 for 1 cycle at pc=8 → pc stays 8, if_id holds the instruction at 4, HOLD entered. Next cycle the instruction at 8 is loaded with no refetch (imem_req=0 in HOLD).
- redirect=1, redirect_pc=32'h40, imem_ready=1 at pc=C → next cycle pc=40, if_id_valid=0, if_id_instr=NOP_INSTR. The following cycle presents the instruction at 40.
- redirect to 32'h80 while imem_ready=0 at pc=10 (3 wait cycles) → imem_addr stays 10 until ready. Data is discarded, then imem_addr=80 and if_id_valid stays 0 throughout.
- redirect=1 with IF_ID_Write=0 → ignored: pc and IF/ID unchanged.
- rst asserted during a wait-state fetch → next cycle pc=0, if_id_valid=0, imem_req=0. A late imem_ready is ignored.
